dino_pixel_stage: RTL and testbench
===================================

# dino_pixel_stage

Pixel-generation stage that sits directly downstream of the VGA timer. Consumes the timer's sync, visible and logical position outputs and draws the Dino Run frame: a 16x16 1-bpp dino sprite, a one-line ground, and background colour. Sync is delayed to match the pixel pipeline, and 12-bit RGB drives the VGA connector. Sprite position updates come through a valid/ready handshake and are applied only at frame boundaries, so frames never tear.

## Interface
- `GROUND_Y`, default 200: logical row drawn as ground.
- `DINO_RGB`, default 12'h0F0: sprite colour {r,g,b}.
- `GROUND_RGB`, default 12'hFFF: ground colour.
- `BG_RGB`, default 12'h000: visible background colour.
- `clk_i`  in  1  pixel clock. Same clock as the timer.
- `rst_i`  in  1  reset. Synchronous, active-high.
- `hsync_i`, `vsync_i`  in  1 each  timer syncs, active-low.
- `visible_i`  in  1  timer visible flag.
- `position_x_i`  in  9  logical x, 0..319.
- `position_y_i`  in  8  logical y, 0..239.
- `pos_valid_i`  in  1  new dino position offered.
- `pos_ready_o`  out  1  position slot free.
- `dino_x_i`  in  9  sprite top-left x.
- `dino_y_i`  in  8  sprite top-left y.
- `bmp_we_i`  in  1  bitmap row write enable.
- `bmp_row_i`  in  4  bitmap row index.
- `bmp_data_i`  in  16  row bits; bit 15 is the leftmost pixel.
- `hsync_o`, `vsync_o`  out  1 each  syncs delayed 2 cycles.
- `red_o`, `green_o`, `blue_o`  out  4 each  pixel colour.
- `frame_start_o`  out  1  one-cycle pulse when new active position takes effect.

## Operation
- **Position handshake.** A transfer occurs on `pos_valid_i && pos_ready_o`.
  - The transfer loads the pending register, and `pos_ready_o` drops the next cycle.
  - Pending holds until a frame boundary.
- **Frame boundary.** Defined as a `vsync_i` falling edge, i.e. registered `vsync_i` is 1 and current `vsync_i` is 0.
  - On the next edge: if pending is full, pending copies to active and pending empties (`pos_ready_o` returns to 1).
  - `frame_start_o` pulses the same cycle the active registers update, whether or not pending was full.
- **Simultaneous transfer and boundary** (pending empty): the transfer goes to pending. It is not applied until the following boundary.
- **Bitmap.** 16 rows x 16 bits of registers, written when `bmp_we_i` is high.
  - A write and a stage-1 read of the same row in one cycle return the old data.
- **Stage 1** (registers inputs):
  - hit = (x ≥ dx) && (x < dx+16) && (y ≥ dy) && (y < dy+16), compared at 10-bit width. A sprite near the right or bottom edge clips and never wraps.
  - col = (x−dx)[3:0], row = (y−dy)[3:0].
  - Register hit, the selected bitmap row, col, visible, the y==GROUND_Y flag, and the syncs.
- **Stage 2** (registers outputs), colour priority:
  1. Not visible: 0.
  2. hit && bitmap bit (15−col): `DINO_RGB`.
  3. Ground row: `GROUND_RGB`.
  4. Otherwise: `BG_RGB`.
- **Reset values:**
  - Outputs: `hsync_o`=1, `vsync_o`=1, RGB=0, `frame_start_o`=0, `pos_ready_o`=1.
  - Internal: pending empty; active = (32, GROUND_Y−16); bitmap all 0; vsync edge register = 1; pipeline syncs = 1; visible flags = 0.
- **Reset mid-frame:** everything returns to the reset values on the next edge. A pending update is discarded.

## Timing
- Latency is 2 cycles from timer inputs to `hsync_o`/`vsync_o`/RGB, identical for all outputs.
- A bitmap write is visible to stage-1 reads from the cycle after the write edge.
- Handshake latency:
  - `pos_ready_o` low 1 cycle after the transfer.
  - High 1 cycle after the boundary edge, coincident with `frame_start_o`.
- At most one position update is applied per frame. A second offer stalls until pending empties.

## Test plan
- **Reset.** Hold `rst_i` 3 cycles. Expect: `hsync_o`=`vsync_o`=1, RGB=0, `pos_ready_o`=1, `frame_start_o`=0.
- **Sprite render.**
  - Stimulus: write row 0 = 16'h8001, position (100,50) applied via a boundary.
  - x=100, y=50: RGB=0F0 two cycles later.
  - x=101: 000. x=115: 0F0. x=116: 000.
- **Handshake.**
  - Offer (200,60) mid-frame: `pos_ready_o`=0 next cycle, and the sprite still renders at the old position.
  - After the `vsync_i` falling edge: `frame_start_o`=1, `pos_ready_o`=1, and the next frame draws at (200,60).
- **Clip.** Position (310,10), row 0 = 16'hFFFF.
  - x=310..319: 0F0.
  - x=0..5 on y=10: 000 (no wrap).
- **Ground and blanking.** y=200, visible=1 → RGB=FFF. Visible=0 → RGB=0 regardless of sprite or ground.
- **Sync and boundary races.**
  - Toggle `hsync_i`: `hsync_o` follows exactly 2 cycles later.
  - Write row 3 in the same cycle it is read: old data is displayed.
  - Transfer on the boundary cycle: applied one frame later.

Source files
------------

// File: rtl/dino_pixel_stage.sv
// dino_pixel_stage
//   Pixel-generation stage fed directly by the VGA timer. Draws a 16x16
//   1-bpp dino sprite, a one-line ground and a background colour, delays the
//   timer syncs to line up with the 2-stage pixel pipeline, and takes sprite
//   position updates through a valid/ready slot that is only applied at a
//   frame boundary (vsync falling edge), so a frame never tears.
//
// Ports
//   clk_i, rst_i                 pixel clock, synchronous active-high reset
//   hsync_i, vsync_i, visible_i  timer syncs (active-low) and visible flag
//   position_x_i, position_y_i   timer logical position (0..319, 0..239)
//   pos_valid_i / pos_ready_o    new sprite position handshake
//   dino_x_i, dino_y_i           offered sprite top-left corner
//   bmp_we_i, bmp_row_i, bmp_data_i  sprite bitmap row write (bit 15 = left)
//   hsync_o, vsync_o             syncs delayed 2 cycles
//   red_o, green_o, blue_o       12-bit pixel colour
//   frame_start_o                pulse when the active position takes effect
module dino_pixel_stage #(
    parameter int unsigned GROUND_Y   = 200,
    parameter logic [11:0] DINO_RGB   = 12'h0F0,
    parameter logic [11:0] GROUND_RGB = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        visible_i,
    input  logic [8:0]  position_x_i,
    input  logic [7:0]  position_y_i,
    input  logic        pos_valid_i,
    output logic        pos_ready_o,
    input  logic [8:0]  dino_x_i,
    input  logic [7:0]  dino_y_i,
    input  logic        bmp_we_i,
    input  logic [3:0]  bmp_row_i,
    input  logic [15:0] bmp_data_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [3:0]  red_o,
    output logic [3:0]  green_o,
    output logic [3:0]  blue_o,
    output logic        frame_start_o
);

    localparam logic [7:0] GROUND_ROW = 8'(GROUND_Y);
    localparam logic [8:0] RESET_X    = 9'd32;
    localparam logic [7:0] RESET_Y    = 8'(GROUND_Y - 16);

    // ------------------------------------------------------------------
    // Position handshake and frame boundary
    // ------------------------------------------------------------------
    logic       vsync_q;
    logic       boundary;
    logic       transfer;
    logic       pend_full;
    logic [8:0] pend_x;
    logic [7:0] pend_y;
    logic [8:0] act_x;
    logic [7:0] act_y;

    always_comb begin
        boundary    = vsync_q & ~vsync_i;
        pos_ready_o = ~pend_full;
        transfer    = pos_valid_i & ~pend_full;
    end

    // A transfer can only happen while pending is empty, so it never
    // competes with the boundary drain: on a simultaneous boundary the
    // (empty) pending slot applies nothing and the new offer simply waits
    // for the next boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vsync_q       <= 1'b1;
            pend_full     <= 1'b0;
            pend_x        <= '0;
            pend_y        <= '0;
            act_x         <= RESET_X;
            act_y         <= RESET_Y;
            frame_start_o <= 1'b0;
        end else begin
            vsync_q       <= vsync_i;
            frame_start_o <= boundary;
            if (transfer) begin
                pend_full <= 1'b1;
                pend_x    <= dino_x_i;
                pend_y    <= dino_y_i;
            end else if (boundary && pend_full) begin
                pend_full <= 1'b0;
                act_x     <= pend_x;
                act_y     <= pend_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sprite bitmap (read-before-write: same-cycle read sees old row)
    // ------------------------------------------------------------------
    logic [15:0] bmp [16];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 16; i++) begin
                bmp[i] <= '0;
            end
        end else if (bmp_we_i) begin
            bmp[bmp_row_i] <= bmp_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test, bitmap row fetch, register timer signals
    // ------------------------------------------------------------------
    logic [9:0] x_ext, y_ext, dx_ext, dy_ext, dx_off, dy_off;
    logic       hit;

    // 10-bit compare so a sprite near the right/bottom edge clips instead
    // of wrapping back to column/row 0.
    always_comb begin
        x_ext  = {1'b0, position_x_i};
        y_ext  = {2'b0, position_y_i};
        dx_ext = {1'b0, act_x};
        dy_ext = {2'b0, act_y};
        dx_off = x_ext - dx_ext;
        dy_off = y_ext - dy_ext;
        hit    = (x_ext >= dx_ext) && (x_ext < dx_ext + 10'd16) &&
                 (y_ext >= dy_ext) && (y_ext < dy_ext + 10'd16);
    end

    logic        s1_hit;
    logic [15:0] s1_bits;
    logic [3:0]  s1_col;
    logic        s1_vis;
    logic        s1_gnd;
    logic        s1_hs;
    logic        s1_vs;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_hit  <= 1'b0;
            s1_bits <= '0;
            s1_col  <= '0;
            s1_vis  <= 1'b0;
            s1_gnd  <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
        end else begin
            s1_hit  <= hit;
            s1_bits <= bmp[dy_off[3:0]];
            s1_col  <= dx_off[3:0];
            s1_vis  <= visible_i;
            s1_gnd  <= (position_y_i == GROUND_ROW);
            s1_hs   <= hsync_i;
            s1_vs   <= vsync_i;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour priority and output registers
    // ------------------------------------------------------------------
    logic [11:0] colour;
    logic        sprite_px;

    always_comb begin
        sprite_px = s1_bits[4'd15 - s1_col];
        colour    = BG_RGB;
        if (!s1_vis) begin
            colour = '0;
        end else if (s1_hit && sprite_px) begin
            colour = DINO_RGB;
        end else if (s1_gnd) begin
            colour = GROUND_RGB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            red_o   <= '0;
            green_o <= '0;
            blue_o  <= '0;
        end else begin
            hsync_o <= s1_hs;
            vsync_o <= s1_vs;
            red_o   <= colour[11:8];
            green_o <= colour[7:4];
            blue_o  <= colour[3:0];
        end
    end

endmodule

// File: tb/tb_dino_pixel_stage.sv
module tb_dino_pixel_stage;

    localparam int K_RGB = 0;
    localparam int K_HS  = 1;
    localparam int K_VS  = 2;
    localparam int K_RDY = 3;
    localparam int K_FS  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_i, vs_i, vis;
    logic [8:0]  px;
    logic [7:0]  py;
    logic        pv;
    logic        rdy;
    logic [8:0]  dx;
    logic [7:0]  dy;
    logic        we;
    logic [3:0]  brow;
    logic [15:0] bdata;
    logic        hs_o, vs_o, fs;
    logic [3:0]  r, g, b;

    dino_pixel_stage #(
        .GROUND_Y  (200),
        .DINO_RGB  (12'h0F0),
        .GROUND_RGB(12'hFFF),
        .BG_RGB    (12'h000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .hsync_i      (hs_i),
        .vsync_i      (vs_i),
        .visible_i    (vis),
        .position_x_i (px),
        .position_y_i (py),
        .pos_valid_i  (pv),
        .pos_ready_o  (rdy),
        .dino_x_i     (dx),
        .dino_y_i     (dy),
        .bmp_we_i     (we),
        .bmp_row_i    (brow),
        .bmp_data_i   (bdata),
        .hsync_o      (hs_o),
        .vsync_o      (vs_o),
        .red_o        (r),
        .green_o      (g),
        .blue_o       (b),
        .frame_start_o(fs)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        int          kind;
        logic [11:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every falling edge, retire all expectations due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [11:0] act;
                case (sb[i].kind)
                    K_RGB:   act = {r, g, b};
                    K_HS:    act = {11'b0, hs_o};
                    K_VS:    act = {11'b0, vs_o};
                    K_RDY:   act = {11'b0, rdy};
                    default: act = {11'b0, fs};
                endcase
                total++;
                if (sb[i].due != cyc) begin
                    bad++;
                    $display("FAIL %s: missed sample slot (due %0d, now %0d)",
                             sb[i].name, sb[i].due, cyc);
                end else if (act !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s: got %03h expected %03h (cycle %0d)",
                             sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int unsigned dly, input int kind,
                             input logic [11:0] val, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [8:0] x, input logic [7:0] y, input logic v,
                       input logic [11:0] exp_rgb, input string name);
        px  = x;
        py  = y;
        vis = v;
        expect_at(2, K_RGB, exp_rgb, name);
        tick();
    endtask

    task automatic write_row(input logic [3:0] row, input logic [15:0] data);
        we    = 1'b1;
        brow  = row;
        bdata = data;
        tick();
        we    = 1'b0;
    endtask

    task automatic offer(input logic [8:0] x, input logic [7:0] y, input string name);
        pv = 1'b1;
        dx = x;
        dy = y;
        expect_at(0, K_RDY, 12'h001, {name, "_rdy_pre"});
        tick();
        pv = 1'b0;
        expect_at(0, K_RDY, 12'h000, {name, "_rdy_low"});
    endtask

    task automatic boundary(input string name);
        vs_i = 1'b0;
        vis  = 1'b0;
        expect_at(1, K_FS, 12'h001, {name, "_fs"});
        expect_at(1, K_RDY, 12'h001, {name, "_rdy"});
        expect_at(2, K_VS, 12'h000, {name, "_vs_o"});
        tick();
        vs_i = 1'b1;
        expect_at(1, K_FS, 12'h000, {name, "_fs_end"});
        tick();
    endtask

    initial begin
        rst = 1'b1; hs_i = 1'b0; vs_i = 1'b1; vis = 1'b1;
        px = 9'd32; py = 8'd184; pv = 1'b0; dx = '0; dy = '0;
        we = 1'b0; brow = '0; bdata = '0;

        // Reset held 3 cycles, checked on the third
        tick();
        tick();
        expect_at(1, K_HS,  12'h001, "rst_hsync");
        expect_at(1, K_VS,  12'h001, "rst_vsync");
        expect_at(1, K_RGB, 12'h000, "rst_rgb");
        expect_at(1, K_RDY, 12'h001, "rst_ready");
        expect_at(1, K_FS,  12'h000, "rst_fs");
        tick();
        rst  = 1'b0;
        hs_i = 1'b1;

        // Sprite render at (100,50), row 0 = 8001
        write_row(4'd0, 16'h8001);
        offer(9'd100, 8'd50, "sp");
        boundary("sp_bnd");
        pix(9'd100, 8'd50, 1'b1, 12'h0F0, "sp_x100");
        pix(9'd101, 8'd50, 1'b1, 12'h000, "sp_x101");
        pix(9'd115, 8'd50, 1'b1, 12'h0F0, "sp_x115");
        pix(9'd116, 8'd50, 1'b1, 12'h000, "sp_x116");
        pix(9'd99,  8'd50, 1'b1, 12'h000, "sp_x99");

        // Handshake: offer mid-frame, old position still drawn
        offer(9'd200, 8'd60, "hs");
        pix(9'd100, 8'd50, 1'b1, 12'h0F0, "hs_old_pos");
        pix(9'd200, 8'd60, 1'b1, 12'h000, "hs_new_not_yet");
        boundary("hs_bnd");
        pix(9'd200, 8'd60, 1'b1, 12'h0F0, "hs_new_pos");
        pix(9'd215, 8'd60, 1'b1, 12'h0F0, "hs_new_right");
        pix(9'd100, 8'd50, 1'b1, 12'h000, "hs_old_gone");
        pix(9'd200, 8'd61, 1'b1, 12'h000, "hs_row1_empty");

        // Clip at right edge, no wrap to column 0
        write_row(4'd0, 16'hFFFF);
        offer(9'd310, 8'd10, "clip");
        boundary("clip_bnd");
        for (int x = 310; x <= 319; x++)
            pix(9'(x), 8'd10, 1'b1, 12'h0F0, "clip_in");
        for (int x = 0; x <= 5; x++)
            pix(9'(x), 8'd10, 1'b1, 12'h000, "clip_nowrap");

        // Ground and blanking
        pix(9'd50,  8'd200, 1'b1, 12'hFFF, "ground");
        pix(9'd310, 8'd10,  1'b0, 12'h000, "blank_sprite");
        pix(9'd50,  8'd200, 1'b0, 12'h000, "blank_ground");

        // hsync delay of exactly 2 cycles
        hs_i = 1'b0;
        expect_at(1, K_HS, 12'h001, "hs_pre");
        expect_at(2, K_HS, 12'h000, "hs_fall");
        tick();
        hs_i = 1'b1;
        expect_at(2, K_HS, 12'h001, "hs_rise");
        tick();

        // Write row 3 while it is being read: old (zero) row is displayed
        we = 1'b1; brow = 4'd3; bdata = 16'hFFFF;
        px = 9'd310; py = 8'd13; vis = 1'b1;
        expect_at(2, K_RGB, 12'h000, "race_old");
        tick();
        we = 1'b0;
        pix(9'd310, 8'd13, 1'b1, 12'h0F0, "race_new");

        // Transfer on the boundary cycle: applied one frame later
        pv = 1'b1; dx = 9'd20; dy = 8'd100; vs_i = 1'b0; vis = 1'b0;
        expect_at(0, K_RDY, 12'h001, "bt_rdy_pre");
        expect_at(1, K_FS,  12'h001, "bt_fs");
        expect_at(1, K_RDY, 12'h000, "bt_rdy_taken");
        tick();
        pv = 1'b0; vs_i = 1'b1;
        expect_at(1, K_FS, 12'h000, "bt_fs_end");
        tick();
        pix(9'd20,  8'd100, 1'b1, 12'h000, "bt_not_yet");
        pix(9'd310, 8'd10,  1'b1, 12'h0F0, "bt_old_kept");
        boundary("bt_bnd2");
        pix(9'd20,  8'd100, 1'b1, 12'h0F0, "bt_applied");
        pix(9'd310, 8'd10,  1'b1, 12'h000, "bt_old_gone");

        // Reset mid-frame discards pending and restores (32,184)
        offer(9'd50, 8'd50, "mr");
        rst = 1'b1;
        expect_at(1, K_RDY, 12'h001, "mr_rdy");
        tick();
        rst = 1'b0;
        write_row(4'd0, 16'h8000);
        boundary("mr_bnd");
        pix(9'd32, 8'd184, 1'b1, 12'h0F0, "mr_reset_pos");
        pix(9'd50, 8'd50,  1'b1, 12'h000, "mr_discarded");
        pix(9'd33, 8'd184, 1'b1, 12'h000, "mr_col1");

        for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, expected 0", sb.size());
            total += sb.size();
            bad   += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
